iob_clint_arbiter: RTL and testbench
====================================

# iob_clint_arbiter

Round-robin arbiter that shares the single native-bus slave port of the core-local interruptor (timer/software-interrupt unit) among N_MASTERS requesters, typically one per core plus an optional debug master. It latches one request at a time, issues it to the slave as a single-cycle valid pulse, waits for the slave's ready, and returns the read data to the granted master only. A watchdog completes stalled transactions so that no master can hang.

## Interface
Parameters:
- ADDR_W, 16, address width of every master and of the slave port
- DATA_W, 32, data width; wstrb width is DATA_W/8
- N_MASTERS, 2, number of requesters, ≥1; index width GW = max(1, clog2(N_MASTERS))
- TIMEOUT, 255, maximum cycles spent in WAIT before forced completion; ≥2, counter width 8 bits minimum

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- m_valid  in  N_MASTERS  request per master; held until matching m_ready
- m_address  in  N_MASTERS*ADDR_W  master i at bits [i*ADDR_W +: ADDR_W]
- m_wdata  in  N_MASTERS*DATA_W  packed likewise
- m_wstrb  in  N_MASTERS*DATA_W/8  packed likewise; nonzero = write
- m_rdata  out  DATA_W  response data, shared; valid only with m_ready
- m_ready  out  N_MASTERS  one-hot, one-cycle completion strobe
- s_valid  out  1  request to slave, one-cycle pulse
- s_address  out  ADDR_W  registered address of granted request
- s_wdata  out  DATA_W  registered write data
- s_wstrb  out  DATA_W/8  registered strobes
- s_rdata  in  DATA_W  slave read data, sampled with s_ready
- s_ready  in  1  slave completion
- grant_idx  out  GW  index of current/last granted master
- timeout_err  out  1  one-cycle pulse when a transaction is force-completed

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state IDLE.
- IDLE: if any m_valid bit is set, select the first set bit scanning from (last+1) mod N_MASTERS upward with wrap; register grant_idx and last ← selected index; latch that master's address/wdata/wstrb into s_address/s_wdata/s_wstrb; → ISSUE. With no requests, stay in IDLE.
- ISSUE: s_valid=1 for exactly this cycle; clear the watchdog counter; → WAIT.
- WAIT: s_valid=0. If s_ready=1, capture s_rdata into the m_rdata register and → RESP. Otherwise increment the watchdog counter; when it reaches TIMEOUT, load m_rdata ← 0, pulse timeout_err, and → RESP.
- RESP: m_ready[grant_idx]=1, all other bits 0; m_rdata holds the captured value; → IDLE.
- s_ready outside WAIT is ignored. This covers a late response after a timeout.
- Round robin: last resets to N_MASTERS-1, so master 0 has first priority after reset. A master granted in one round has lowest priority in the next arbitration.
- m_valid changes of non-granted masters during ISSUE/WAIT/RESP have no effect. The latched request is immune to master-side changes after the grant.
- The granted master deasserts or renews m_valid on the edge ending RESP. IDLE therefore samples a fresh value, so there is no double grant.
- N_MASTERS=1: arbitration degenerates and grant_idx is always 0.
- Reset (any state, asynchronous): state ← IDLE; s_valid, m_ready, timeout_err ← 0; s_address, s_wdata, s_wstrb, m_rdata ← 0; grant_idx ← 0; last ← N_MASTERS-1; watchdog ← 0. An in-flight transaction is abandoned with no m_ready.

## Timing
- Edge e0: IDLE samples m_valid. Cycle after e0: s_valid=1.
- Slave registered-ready (ready ≤ valid): s_ready high in the cycle after e1. Edge e2 → RESP, so m_ready is high in the cycle after e2. e3 → IDLE.
- Request-to-ready latency is 3 cycles after the sampling edge. Back-to-back throughput is one transaction per 4 cycles.
- Timeout path: m_ready asserts TIMEOUT+2 cycles after the ISSUE cycle. timeout_err is coincident with the cycle that enters RESP's data load, i.e. high during RESP.
- All outputs are registered. There is no combinational path from m_* or s_* inputs to any output.

## Test plan
- Reset with m_valid=2'b11: all outputs 0. First grant after rst release → master 0, s_valid single pulse, m_ready=2'b01 3 cycles after the sampling edge.
- Both masters hold continuous requests: grants alternate 0,1,0,1. Master 0 writes 0x1 to address 0x0000; master 1 reads 0x0000 and gets m_rdata=0x00000001 with m_ready=2'b10.
- N_MASTERS=3, masters 1 and 2 request, last=1: grant goes to 2, then 1 (wrap-around order verified).
- Slave never asserts s_ready, TIMEOUT=4: m_ready pulses at ISSUE+6, m_rdata=0, timeout_err=1 for one cycle. A later stray s_ready causes no m_ready.
- Master 1 changes m_address from 0x4000 to 0xbff8 during WAIT: s_address stays 0x4000 until the transaction completes.
- rst asserted during WAIT: next cycle state is IDLE and s_valid/m_ready=0. After release, master 0 is granted first.

Source files
------------

// File: rtl/iob_clint_arbiter.sv
// Round-robin arbiter sharing the CLINT native-bus slave port among N_MASTERS requesters.
// One request is latched per grant; a watchdog force-completes stalled slave accesses.
module iob_clint_arbiter #(
  parameter  int ADDR_W    = 16,
  parameter  int DATA_W    = 32,
  parameter  int N_MASTERS = 2,
  parameter  int TIMEOUT   = 255,
  localparam int GW        = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1,
  localparam int SW        = DATA_W / 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_MASTERS-1:0]      m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0] m_address,
  input  logic [N_MASTERS*DATA_W-1:0] m_wdata,
  input  logic [N_MASTERS*SW-1:0]   m_wstrb,
  output logic [DATA_W-1:0]         m_rdata,
  output logic [N_MASTERS-1:0]      m_ready,
  output logic                      s_valid,
  output logic [ADDR_W-1:0]         s_address,
  output logic [DATA_W-1:0]         s_wdata,
  output logic [SW-1:0]             s_wstrb,
  input  logic [DATA_W-1:0]         s_rdata,
  input  logic                      s_ready,
  output logic [GW-1:0]             grant_idx,
  output logic                      timeout_err
);

  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [GW-1:0] LAST_RST = GW'(N_MASTERS - 1);
  localparam logic [CW-1:0] WDOG_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state;
  logic [GW-1:0]     last;
  logic [CW-1:0]     wdog;
  logic [GW-1:0]     sel;
  logic              sel_found;
  logic [N_MASTERS-1:0] grant_oh;

  // First requester after the previously granted one, wrapping around.
  always_comb begin
    int cand;
    cand      = 0;
    sel       = '0;
    sel_found = 1'b0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      cand = (int'(last) + k) % N_MASTERS;
      if (!sel_found && m_valid[cand[GW-1:0]]) begin
        sel       = cand[GW-1:0];
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    grant_oh            = '0;
    grant_oh[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last        <= LAST_RST;
      grant_idx   <= '0;
      wdog        <= '0;
      s_valid     <= 1'b0;
      s_address   <= '0;
      s_wdata     <= '0;
      s_wstrb     <= '0;
      m_rdata     <= '0;
      m_ready     <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            grant_idx <= sel;
            last      <= sel;
            s_address <= m_address[int'(sel)*ADDR_W +: ADDR_W];
            s_wdata   <= m_wdata[int'(sel)*DATA_W +: DATA_W];
            s_wstrb   <= m_wstrb[int'(sel)*SW +: SW];
            s_valid   <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          s_valid <= 1'b0;
          wdog    <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          // A slave response in the final watchdog cycle still wins over the timeout.
          if (s_ready) begin
            m_rdata <= s_rdata;
            m_ready <= grant_oh;
            state   <= RESP;
          end else if (wdog == WDOG_MAX) begin
            m_rdata     <= '0;
            timeout_err <= 1'b1;
            m_ready     <= grant_oh;
            state       <= RESP;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        RESP: begin
          m_ready     <= '0;
          timeout_err <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_clint_arbiter.sv
// Scoreboard bench for iob_clint_arbiter: randomized masters and slave, queue-based
// reference of grant order, response data and completion cycle.
module tb_iob_clint_arbiter;
  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;
  localparam int GW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      m_valid;
  logic [N*AW-1:0]   m_address;
  logic [N*DW-1:0]   m_wdata;
  logic [N*SW-1:0]   m_wstrb;
  logic [DW-1:0]     m_rdata;
  logic [N-1:0]      m_ready;
  logic              s_valid;
  logic [AW-1:0]     s_address;
  logic [DW-1:0]     s_wdata;
  logic [SW-1:0]     s_wstrb;
  logic [DW-1:0]     s_rdata;
  logic              s_ready;
  logic [GW-1:0]     grant_idx;
  logic              timeout_err;

  iob_clint_arbiter #(.ADDR_W(AW), .DATA_W(DW), .N_MASTERS(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_address(m_address), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_rdata(m_rdata), .m_ready(m_ready), .s_valid(s_valid),
    .s_address(s_address), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .s_ready(s_ready), .grant_idx(grant_idx), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    int            gap;
    int            chg_at;
    logic [AW-1:0] chg_addr;
  } cmd_t;

  typedef struct {
    int            g;
    logic [DW-1:0] rdata;
    logic          to;
    int            cyc;
    logic [AW-1:0] addr;
  } exp_t;

  cmd_t cmdq [N][$];
  exp_t sb [$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   force_plan = 0;   // -2 random, -1 slave hangs, >=0 fixed ready delay

  logic [AW-1:0] ra [N];
  logic [DW-1:0] rd [N];
  logic [SW-1:0] rs [N];
  logic [N-1:0]    mv_e;
  logic [N*AW-1:0] ae;
  logic [N*DW-1:0] we;
  logic [N*SW-1:0] se;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic bad(input string msg);
    n_vec++;
    n_err++;
    $display("FAIL %s", msg);
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [SW-1:0] s);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < SW; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Request state each master presented at the edge just passed.
  always @(posedge clk) begin
    mv_e <= m_valid;
    ae   <= m_address;
    we   <= m_wdata;
    se   <= m_wstrb;
  end

  always_comb begin
    m_address = '0;
    m_wdata   = '0;
    m_wstrb   = '0;
    for (int i = 0; i < N; i++) begin
      m_address[i*AW +: AW] = ra[i];
      m_wdata[i*DW +: DW]   = rd[i];
      m_wstrb[i*SW +: SW]   = rs[i];
    end
  end

  // Master driver: holds each request until its m_ready, optionally altering the address meanwhile.
  initial begin
    logic [N-1:0] rdy;
    cmd_t cur [N];
    int   age [N];
    int   gap [N];
    m_valid = '0;
    for (int i = 0; i < N; i++) begin
      ra[i] = '0; rd[i] = '0; rs[i] = '0; age[i] = 0; gap[i] = 0;
    end
    forever begin
      @(negedge clk);
      rdy = m_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (m_valid[i] && rdy[i]) m_valid[i] = 1'b0;
        if (m_valid[i]) begin
          age[i]++;
          if (age[i] == cur[i].chg_at) ra[i] = cur[i].chg_addr;
        end else if (cmdq[i].size() > 0) begin
          if (gap[i] >= cmdq[i][0].gap) begin
            cur[i] = cmdq[i].pop_front();
            ra[i] = cur[i].addr; rd[i] = cur[i].wdata; rs[i] = cur[i].wstrb;
            m_valid[i] = 1'b1;
            age[i] = 0;
            gap[i] = 0;
          end else begin
            gap[i]++;
          end
        end
      end
    end
  end

  // Slave model and request-side reference: predicts the grant, checks the issued request,
  // pushes the expected completion, then answers (or hangs).
  initial begin
    int            prio [$];
    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] slv_mem [16];
    int            g, d, c;
    logic          to;
    logic [AW-1:0] a;
    logic [DW-1:0] rdat;
    s_ready = 1'b0;
    s_rdata = '0;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 32'hA500_0000 + 32'h0001_0101 * i;
      slv_mem[i] = ref_mem[i];
    end
    for (int i = 0; i < N; i++) prio.push_back(i);
    forever begin
      @(negedge clk);
      if (rst) begin
        prio = {};
        for (int i = 0; i < N; i++) prio.push_back(i);
      end else if (s_valid) begin
        c = cyc;
        g = -1;
        for (int k = 0; k < N; k++) if (g < 0 && mv_e[prio[k]]) g = prio[k];
        if (g < 0) begin
          bad($sformatf("spurious_issue: actual s_valid=1 required 0 (mv=%b)", mv_e));
        end else begin
          while (prio[N-1] != g) prio.push_back(prio.pop_front());
          a = ae[g*AW +: AW];
          chk("issue_grant_idx", 64'(grant_idx), 64'(g));
          chk("issue_s_address", 64'(s_address), 64'(a));
          chk("issue_s_wdata", 64'(s_wdata), 64'(we[g*DW +: DW]));
          chk("issue_s_wstrb", 64'(s_wstrb), 64'(se[g*SW +: SW]));
          to = 1'b0;
          d  = 0;
          if (force_plan == -2) begin
            if ($urandom_range(0, 5) == 0) to = 1'b1;
            else d = $urandom_range(0, 4);
          end else if (force_plan < 0) begin
            to = 1'b1;
          end else begin
            d = force_plan;
          end
          if (to) begin
            rdat = '0;
          end else begin
            rdat = ref_mem[a[5:2]];
            ref_mem[a[5:2]] = merge(ref_mem[a[5:2]], we[g*DW +: DW], se[g*SW +: SW]);
          end
          sb.push_back('{g: g, rdata: rdat, to: to, cyc: to ? c + TO + 2 : c + d + 2, addr: a});
          if (!to) begin
            repeat (d + 1) @(posedge clk);
            #1;
            s_ready = 1'b1;
            s_rdata = slv_mem[s_address[5:2]];
            slv_mem[s_address[5:2]] = merge(slv_mem[s_address[5:2]], s_wdata, s_wstrb);
            @(posedge clk);
            #1;
            s_ready = 1'b0;
            s_rdata = $urandom;
          end else begin
            // Late response arriving while the arbiter is in RESP and then IDLE.
            repeat (TO + 2) @(posedge clk);
            #1;
            s_ready = 1'b1;
            s_rdata = $urandom;
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
            s_ready = 1'b0;
          end
        end
      end
    end
  end

  // Response monitor.
  initial begin
    exp_t e;
    logic sv_prev;
    sv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        sv_prev = 1'b0;
      end else begin
        if (s_valid) chk("s_valid_single_pulse", 64'(sv_prev), 64'd0);
        sv_prev = s_valid;
        if (m_ready != '0) begin
          if (sb.size() == 0) begin
            bad($sformatf("unexpected_m_ready: actual %b required 000", m_ready));
          end else begin
            e = sb.pop_front();
            chk("resp_m_ready", 64'(m_ready), 64'(1) << e.g);
            chk("resp_m_rdata", 64'(m_rdata), 64'(e.rdata));
            chk("resp_timeout_err", 64'(timeout_err), 64'(e.to));
            chk("resp_cycle", 64'(cyc), 64'(e.cyc));
            chk("resp_s_address_held", 64'(s_address), 64'(e.addr));
          end
        end else if (timeout_err) begin
          bad("timeout_err_without_m_ready: actual 1 required 0");
        end
      end
    end
  end

  task automatic push(input int m, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input logic [SW-1:0] ws, input int gp, input int chg, input logic [AW-1:0] ca);
    cmdq[m].push_back('{addr: a, wdata: wd, wstrb: ws, gap: gp, chg_at: chg, chg_addr: ca});
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 3000 && !done; t++) begin
      @(negedge clk);
      if (cmdq[0].size() == 0 && cmdq[1].size() == 0 && cmdq[2].size() == 0 &&
          m_valid == '0 && sb.size() == 0) done = 1'b1;
    end
    if (!done) bad($sformatf("%s_drain_timeout: pending=%0d required 0", name, sb.size()));
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_issue(input string name);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 60 && !seen; t++) begin
      @(negedge clk);
      if (s_valid) seen = 1'b1;
    end
    if (!seen) bad($sformatf("%s_no_issue: actual s_valid=0 required 1", name));
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    force_plan = 0;
    // Master 0 writes 1 to 0x0000, master 1 then reads it back.
    push(0, 16'h0000, 32'h0000_0001, 4'hF, 0, -1, '0);
    push(1, 16'h0000, 32'h0, 4'h0, 0, -1, '0);
    repeat (3) @(negedge clk);
    chk("rst_s_valid", 64'(s_valid), 64'd0);
    chk("rst_m_ready", 64'(m_ready), 64'd0);
    chk("rst_timeout_err", 64'(timeout_err), 64'd0);
    chk("rst_grant_idx", 64'(grant_idx), 64'd0);
    chk("rst_s_address", 64'(s_address), 64'd0);
    chk("rst_s_wdata", 64'(s_wdata), 64'd0);
    chk("rst_s_wstrb", 64'(s_wstrb), 64'd0);
    chk("rst_m_rdata", 64'(m_rdata), 64'd0);
    rst = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clk);
      if (m_ready == 3'b010) begin
        seen = 1'b1;
        chk("readback_m_rdata", 64'(m_rdata), 64'h1);
      end
    end
    if (!seen) bad("readback_no_m_ready: actual none required 010");
    drain("first");

    // Continuous requests from masters 0 and 1, then 1 and 2 for wrap-around.
    force_plan = -2;
    for (int k = 0; k < 2; k++) begin
      push(0, 16'h0010 + 16'(4*k), $urandom, 4'h0, 0, -1, '0);
      push(1, 16'h0020 + 16'(4*k), $urandom, 4'hF, 0, -1, '0);
    end
    drain("alternate");
    push(1, 16'h0004, $urandom, 4'h3, 0, -1, '0);
    push(2, 16'h0008, $urandom, 4'h0, 0, -1, '0);
    push(1, 16'h000C, $urandom, 4'h0, 0, -1, '0);
    drain("wrap");

    // Hanging slave.
    force_plan = -1;
    push(2, 16'h0030, $urandom, 4'hF, 0, -1, '0);
    drain("timeout");

    // Address altered by the master while its request is in WAIT.
    force_plan = 2;
    push(1, 16'h4000, $urandom, 4'h0, 0, 3, 16'hBFF8);
    drain("addr_change");

    // Reset while a transaction is in WAIT.
    force_plan = -1;
    push(1, 16'h0100, $urandom, 4'hF, 0, -1, '0);
    wait_issue("rst_wait");
    push(0, 16'h0104, $urandom, 4'h0, 0, -1, '0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_wait_s_valid", 64'(s_valid), 64'd0);
    chk("rst_in_wait_m_ready", 64'(m_ready), 64'd0);
    chk("rst_in_wait_grant_idx", 64'(grant_idx), 64'd0);
    force_plan = 1;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    wait_issue("after_rst");
    chk("after_rst_first_grant", 64'(grant_idx), 64'd0);
    drain("after_rst");

    // Randomized traffic.
    force_plan = -2;
    for (int k = 0; k < 80; k++) begin
      push($urandom_range(0, N - 1), 16'($urandom), $urandom,
           ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0, $urandom_range(0, 4),
           ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : -1, 16'($urandom));
    end
    drain("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench timeout");
  end

endmodule
